// File: rtl/mips_multicycle_ctrl_if.sv
// mips_multicycle_ctrl_if: instruction fields and ALU zero flag into the controller, datapath controls out.
interface mips_multicycle_ctrl_if;
  logic [5:0] op;
  logic [5:0] funct;
  logic       zero;
  logic       iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca, pcen, illegal_op, retire;
  logic [1:0] alusrcb, pcsrc;
  logic [2:0] alucontrol;
  logic [3:0] state;
  modport master (input op, funct, zero,
                  output iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca, alusrcb,
                         pcsrc, pcen, alucontrol, state, illegal_op, retire);
  modport slave  (output op, funct, zero,
                  input iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca, alusrcb,
                        pcsrc, pcen, alucontrol, state, illegal_op, retire);
endinterface

// File: rtl/mips_multicycle_ctrl.sv
// mips_multicycle_ctrl: Moore main controller for the multi-cycle MIPS datapath.
// Define MC_CTRL_ADDI_EN to enable the addi path (states 9 and 10).
module mips_multicycle_ctrl (
  input  logic                          clk,
  input  logic                          reset_n,
  mips_multicycle_ctrl_if.master        bus
);
  localparam logic [3:0] S_FETCH = 4'd0, S_DECODE = 4'd1, S_MEMADR = 4'd2, S_MEMRD = 4'd3,
                         S_MEMWB = 4'd4, S_MEMWR = 4'd5, S_EXECUTE = 4'd6, S_ALUWB = 4'd7,
                         S_BRANCH = 4'd8, S_ADDIEX = 4'd9, S_ADDIWB = 4'd10, S_JUMP = 4'd11,
                         S_IDLE = 4'd12;
  localparam logic [5:0] OP_R = 6'b000000, OP_LW = 6'b100011, OP_SW = 6'b101011,
                         OP_BEQ = 6'b000100, OP_ADDI = 6'b001000, OP_J = 6'b000010;
`ifdef MC_CTRL_ADDI_EN
  localparam bit ADDI_EN = 1'b1;
`else
  localparam bit ADDI_EN = 1'b0;
`endif
  logic [3:0] r_state, w_next, w_s;
  logic       r_active, w_funct_ok, w_legal, w_pcwrite, w_branch;
  logic [2:0] w_rfn;
  assign w_funct_ok = bus.funct inside {6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
  assign w_rfn = bus.funct == 6'b100000 ? 3'b010 :
                 bus.funct == 6'b100010 ? 3'b110 :
                 bus.funct == 6'b100100 ? 3'b000 :
                 bus.funct == 6'b100101 ? 3'b001 : 3'b111;
  assign w_legal = bus.op inside {OP_LW, OP_SW, OP_BEQ, OP_J} ||
                   (bus.op == OP_R && w_funct_ok) || (bus.op == OP_ADDI && ADDI_EN);
  // Outputs are decoded from an effective state: idle (all zero) until the first edge after
  // reset release, and for the addi encodings when that path is compiled out.
  assign w_s = (!r_active || (!ADDI_EN && (r_state == S_ADDIEX || r_state == S_ADDIWB))) ? S_IDLE : r_state;
  always_comb begin
    w_next = S_FETCH;
    case (w_s)
      S_FETCH:   w_next = S_DECODE;
      S_DECODE:  w_next = !w_legal ? S_FETCH :
                          (bus.op == OP_LW || bus.op == OP_SW) ? S_MEMADR :
                          bus.op == OP_R ? S_EXECUTE :
                          bus.op == OP_BEQ ? S_BRANCH :
                          bus.op == OP_ADDI ? S_ADDIEX : S_JUMP;
      S_MEMADR:  w_next = bus.op == OP_SW ? S_MEMWR : S_MEMRD;
      S_MEMRD:   w_next = S_MEMWB;
      S_EXECUTE: w_next = S_ALUWB;
      S_ADDIEX:  w_next = S_ADDIWB;
      default:   w_next = S_FETCH;
    endcase
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= S_FETCH;
      r_active <= 1'b0;
    end else begin
      r_active <= 1'b1;
      if (r_active) r_state <= w_next;
    end
  end
  assign w_pcwrite      = w_s == S_FETCH || w_s == S_JUMP;
  assign w_branch       = w_s == S_BRANCH;
  assign bus.pcen       = w_pcwrite || (w_branch && bus.zero);
  assign bus.irwrite    = w_s == S_FETCH;
  assign bus.iord       = w_s == S_MEMRD || w_s == S_MEMWR;
  assign bus.memwrite   = w_s == S_MEMWR;
  assign bus.regdst     = w_s == S_ALUWB;
  assign bus.memtoreg   = w_s == S_MEMWB;
  assign bus.regwrite   = w_s inside {S_MEMWB, S_ALUWB, S_ADDIWB};
  assign bus.alusrca    = w_s inside {S_MEMADR, S_EXECUTE, S_BRANCH, S_ADDIEX};
  assign bus.alusrcb    = w_s == S_FETCH ? 2'b01 : w_s == S_DECODE ? 2'b11 :
                          (w_s == S_MEMADR || w_s == S_ADDIEX) ? 2'b10 : 2'b00;
  assign bus.pcsrc      = w_branch ? 2'b01 : w_s == S_JUMP ? 2'b10 : 2'b00;
  assign bus.alucontrol = w_s == S_EXECUTE ? w_rfn : w_branch ? 3'b110 : w_s < S_IDLE ? 3'b010 : 3'b000;
  assign bus.illegal_op = w_s == S_DECODE && !w_legal;
  assign bus.retire     = w_s inside {S_MEMWB, S_MEMWR, S_ALUWB, S_BRANCH, S_ADDIWB, S_JUMP};
  assign bus.state      = r_state;
endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// tb_mips_multicycle_ctrl: scoreboard bench; expected control words are queued per cycle and
// compared at the falling edge, mid-cycle.
module tb_mips_multicycle_ctrl;
  typedef struct packed {
    logic iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca;
    logic [1:0] alusrcb, pcsrc;
    logic pcen;
    logic [2:0] alu;
    logic ill, ret;
    logic [3:0] st;
  } ctl_t;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int n_checks = 0;
  int n_fail = 0;
  ctl_t q[$];
  mips_multicycle_ctrl_if bus();
  mips_multicycle_ctrl dut (.clk(clk), .reset_n(reset_n), .bus(bus));
  always #5 clk = ~clk;
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  function automatic ctl_t cur();
    return {bus.iord, bus.memwrite, bus.irwrite, bus.regdst, bus.memtoreg, bus.regwrite, bus.alusrca,
            bus.alusrcb, bus.pcsrc, bus.pcen, bus.alucontrol, bus.illegal_op, bus.retire, bus.state};
  endfunction
  function automatic ctl_t ev(input logic [3:0] s, input logic [2:0] aex, input logic ill, input logic z);
    ctl_t e = '0;
    e.st = s;
    e.alu = 3'b010;
    case (s)
      4'd0:  begin e.irwrite = 1; e.pcen = 1; e.alusrcb = 2'b01; end
      4'd1:  begin e.alusrcb = 2'b11; e.ill = ill; end
      4'd2:  begin e.alusrca = 1; e.alusrcb = 2'b10; end
      4'd3:  e.iord = 1;
      4'd4:  begin e.memtoreg = 1; e.regwrite = 1; e.ret = 1; end
      4'd5:  begin e.iord = 1; e.memwrite = 1; e.ret = 1; end
      4'd6:  begin e.alusrca = 1; e.alu = aex; end
      4'd7:  begin e.regdst = 1; e.regwrite = 1; e.ret = 1; end
      4'd8:  begin e.alusrca = 1; e.alu = 3'b110; e.pcsrc = 2'b01; e.pcen = z; e.ret = 1; end
      4'd9:  begin e.alusrca = 1; e.alusrcb = 2'b10; end
      4'd10: begin e.regwrite = 1; e.ret = 1; end
      4'd11: begin e.pcsrc = 2'b10; e.pcen = 1; e.ret = 1; end
      default: e = '0;
    endcase
    return e;
  endfunction
  task automatic push_seq(input int n, input logic [23:0] seq, input logic [2:0] aex, input logic ill, input logic z);
    for (int i = 0; i < n; i++) q.push_back(ev(seq[4*(n-1-i) +: 4], aex, ill, z));
  endtask
  task automatic drive(input logic [5:0] op, input logic [5:0] funct, input logic z);
    bus.op = op;
    bus.funct = funct;
    bus.zero = z;
  endtask
  task automatic test_reset();
    ctl_t got, exp;
    drive(6'b100011, 6'b0, 1'b1);
    repeat (3) begin
      q.push_back('0);
      @(negedge clk);
      got = cur(); exp = q.pop_front(); n_checks++;
      if (got !== exp) begin n_fail++; $display("FAIL reset: got %h expected %h", got, exp); end
    end
    reset_n = 1'b1;
    @(negedge clk);
  endtask
  task automatic test_lw();
    ctl_t got, exp;
    drive(6'b100011, 6'b000000, 1'b1);
    push_seq(5, 24'h01234, 3'b010, 1'b0, 1'b1);
    repeat (5) begin
      got = cur(); exp = q.pop_front(); n_checks++;
      if (got !== exp) begin n_fail++; $display("FAIL lw st=%0d: got %h expected %h", exp.st, got, exp); end
      @(negedge clk);
    end
  endtask
  task automatic test_rtype();
    ctl_t got, exp;
    logic [5:0] f[5] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
    logic [2:0] a[5] = '{3'b010, 3'b110, 3'b000, 3'b001, 3'b111};
    for (int k = 0; k < 5; k++) begin
      drive(6'b000000, f[k], 1'b0);
      push_seq(4, 24'h0167, a[k], 1'b0, 1'b0);
      repeat (4) begin
        got = cur(); exp = q.pop_front(); n_checks++;
        if (got !== exp) begin n_fail++; $display("FAIL rtype funct=%b st=%0d: got %h expected %h", f[k], exp.st, got, exp); end
        @(negedge clk);
      end
    end
  endtask
  task automatic test_beq();
    ctl_t got, exp;
    for (int z = 1; z >= 0; z--) begin
      drive(6'b000100, 6'b0, z[0]);
      push_seq(3, 24'h018, 3'b010, 1'b0, z[0]);
      repeat (3) begin
        got = cur(); exp = q.pop_front(); n_checks++;
        if (got !== exp) begin n_fail++; $display("FAIL beq zero=%0d st=%0d: got %h expected %h", z, exp.st, got, exp); end
        @(negedge clk);
      end
    end
  endtask
  task automatic test_illegal();
    ctl_t got, exp;
    logic [11:0] cases[3] = '{{6'b111111, 6'b100000}, {6'b000000, 6'b000000}, {6'b000000, 6'b100001}};
    for (int k = 0; k < 3; k++) begin
      drive(cases[k][11:6], cases[k][5:0], 1'b1);
      push_seq(2, 24'h01, 3'b010, 1'b1, 1'b1);
      repeat (2) begin
        got = cur(); exp = q.pop_front(); n_checks++;
        if (got !== exp) begin n_fail++; $display("FAIL illegal %b st=%0d: got %h expected %h", cases[k], exp.st, got, exp); end
        @(negedge clk);
      end
    end
  endtask
  task automatic test_reset_mid_sw();
    ctl_t got, exp;
    drive(6'b101011, 6'b0, 1'b0);
    push_seq(3, 24'h012, 3'b010, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      got = cur(); exp = q.pop_front(); n_checks++;
      if (got !== exp) begin n_fail++; $display("FAIL sw_pre st=%0d: got %h expected %h", exp.st, got, exp); end
      if (i < 2) @(negedge clk);
    end
    reset_n = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      q.push_back('0);
      got = cur(); exp = q.pop_front(); n_checks++;
      if (got !== exp) begin n_fail++; $display("FAIL sw_reset: got %h expected %h", got, exp); end
      @(negedge clk);
    end
    reset_n = 1'b1;
    @(negedge clk);
    push_seq(4, 24'h0125, 3'b010, 1'b0, 1'b0);
    repeat (4) begin
      got = cur(); exp = q.pop_front(); n_checks++;
      if (got !== exp) begin n_fail++; $display("FAIL sw_resume st=%0d: got %h expected %h", exp.st, got, exp); end
      @(negedge clk);
    end
  endtask
  task automatic test_addi();
    ctl_t got, exp;
    int n;
    drive(6'b001000, 6'b0, 1'b0);
`ifdef MC_CTRL_ADDI_EN
    n = 4;
    push_seq(4, 24'h019A, 3'b010, 1'b0, 1'b0);
`else
    n = 2;
    push_seq(2, 24'h01, 3'b010, 1'b1, 1'b0);
`endif
    repeat (n) begin
      got = cur(); exp = q.pop_front(); n_checks++;
      if (got !== exp) begin n_fail++; $display("FAIL addi st=%0d: got %h expected %h", exp.st, got, exp); end
      @(negedge clk);
    end
  endtask
  task automatic test_back_to_back();
    ctl_t got, exp;
    logic [5:0] ops[3] = '{6'b101011, 6'b000010, 6'b100011};
    logic [23:0] seqs[3] = '{24'h0125, 24'h01B, 24'h01234};
    int lens[3] = '{4, 3, 5};
    for (int k = 0; k < 3; k++) begin
      drive(ops[k], 6'b0, 1'b1);
      push_seq(lens[k], seqs[k], 3'b010, 1'b0, 1'b1);
      repeat (lens[k]) begin
        got = cur(); exp = q.pop_front(); n_checks++;
        if (got !== exp) begin n_fail++; $display("FAIL b2b op=%b st=%0d: got %h expected %h", ops[k], exp.st, got, exp); end
        @(negedge clk);
      end
    end
    got = cur(); n_checks++;
    if (got.st !== 4'd0) begin n_fail++; $display("FAIL b2b_end: state %0d expected 0", got.st); end
  endtask
  initial begin
    drive(6'b0, 6'b0, 1'b0);
    test_reset();
    test_lw();
    test_rtype();
    test_beq();
    test_illegal();
    test_reset_mid_sw();
    test_addi();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
